// File: rtl/cvxif_pkg.sv
// Shared X-interface coprocessor types: PE scheduler FSM states and the
// layout of one in-flight instruction entry.
package cvxif_pkg;

  localparam int unsigned XIF_ID_W = 4;
  localparam int unsigned XIF_RD_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [XIF_ID_W-1:0] id;
    logic [XIF_RD_W-1:0] rd;
    logic                committed;
    logic                killed;
  } sched_entry_t;

endpackage

// File: rtl/pe_scheduler.sv
// Tracks offloaded instructions from issue to commit, launches the PE in program
// order once each head is committed, and returns results over valid/ready.
module pe_scheduler
  import cvxif_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ID_W   = XIF_ID_W,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic                       issue_accept_i,
  input  logic [ID_W-1:0]            issue_id_i,
  input  logic [4:0]                 issue_rd_i,
  input  logic                       commit_valid_i,
  input  logic [ID_W-1:0]            commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       pe_start_o,
  input  logic                       pe_finished_i,
  input  logic [DATA_W-1:0]          pe_result_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [ID_W-1:0]            result_id_o,
  output logic [4:0]                 result_rd_o,
  output logic [DATA_W-1:0]          result_data_o,
  output logic                       result_we_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [1:0]                 state_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  if (ID_W != XIF_ID_W) begin : g_id_w_check
    $error("pe_scheduler: ID_W must equal cvxif_pkg::XIF_ID_W");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("pe_scheduler: DEPTH must be a power of two and at least 2");
  end

  // Result handshake: result_valid_o rises in RESP and holds with a frozen
  // payload until the cycle result_ready_i is high, which pops the head entry.
  // result_ready_i while result_valid_o is low has no effect.

  sched_state_e          state_q, state_d;
  sched_entry_t          entries_q [DEPTH];
  sched_entry_t          entries_d [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ID_W-1:0]       res_id_q, res_id_d;
  logic [4:0]            res_rd_q, res_rd_d;
  logic [DATA_W-1:0]     res_data_q, res_data_d;

  logic                  enq;
  logic                  pop;
  logic                  head_valid;
  logic                  same_cycle_commit;
  sched_entry_t          head_e;
  logic [PTR_W-1:0]      slot_off [DEPTH];
  logic [DEPTH-1:0]      slot_valid;

  assign issue_ready_o     = (count_q < CNT_W'(DEPTH));
  assign enq               = issue_valid_i & issue_ready_o & issue_accept_i;
  assign head_valid        = (count_q != '0);
  assign head_e            = entries_q[head_q];
  assign same_cycle_commit = commit_valid_i && (commit_id_i == issue_id_i);

  // A slot is occupied when its distance from head (mod DEPTH) is below count.
  always_comb begin
    slot_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off[i]   = PTR_W'(i) - head_q;
      slot_valid[i] = (CNT_W'(slot_off[i]) < count_q);
    end
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    pe_start_o = 1'b0;
    res_id_d   = res_id_q;
    res_rd_d   = res_rd_q;
    res_data_d = res_data_q;
    case (state_q)
      IDLE: begin
        if (head_valid && head_e.committed) begin
          if (head_e.killed) begin
            pop = 1'b1;
          end else begin
            state_d = START;
          end
        end
      end
      START: begin
        pe_start_o = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        if (pe_finished_i) begin
          res_id_d   = head_e.id;
          res_rd_d   = head_e.rd;
          res_data_d = pe_result_i;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (result_ready_i) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Commit matching also covers the entry being written this cycle, so an
  // issue and its commit may arrive together.
  always_comb begin
    entries_d = entries_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (commit_valid_i && slot_valid[i] && !entries_q[i].committed &&
          (entries_q[i].id == commit_id_i)) begin
        entries_d[i].committed = 1'b1;
        entries_d[i].killed    = commit_kill_i;
      end
    end
    if (pop) begin
      entries_d[head_q] = '0;
    end
    if (enq) begin
      entries_d[tail_q].id        = issue_id_i;
      entries_d[tail_q].rd        = issue_rd_i;
      entries_d[tail_q].committed = same_cycle_commit;
      entries_d[tail_q].killed    = same_cycle_commit && commit_kill_i;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (enq) begin
      tail_d = tail_q + PTR_W'(1);
    end
    case ({enq, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      res_id_q   <= '0;
      res_rd_q   <= '0;
      res_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      res_id_q   <= res_id_d;
      res_rd_q   <= res_rd_d;
      res_data_q <= res_data_d;
      entries_q  <= entries_d;
    end
  end

  assign result_valid_o = (state_q == RESP);
  assign result_we_o    = result_valid_o;
  assign result_id_o    = res_id_q;
  assign result_rd_o    = res_rd_q;
  assign result_data_o  = res_data_q;
  assign busy_o         = (state_q != IDLE) || (count_q != '0);
  assign count_o        = count_q;
  assign state_o        = state_q;

endmodule
